// File: rtl/bram_port_arb_if.sv
// Requester and RAM-port signals for bram_port_arb, bundled as one interface.
// master: requesters plus the RAM model; slave: the arbiter.
interface bram_port_arb_if #(
  parameter int DATA = 15,
  parameter int ADDR = 6,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_wr;
  logic [NREQ*ADDR-1:0] req_addr;
  logic [NREQ*DATA-1:0] req_din;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      rd_valid;
  logic [DATA-1:0]      rd_data;
  logic                 ram_wr;
  logic [ADDR-1:0]      ram_addr;
  logic [DATA-1:0]      ram_din;
  logic [DATA-1:0]      ram_dout;

  modport master (
    output req, req_wr, req_addr, req_din, ram_dout,
    input  gnt, rd_valid, rd_data, ram_wr, ram_addr, ram_din
  );

  modport slave (
    input  req, req_wr, req_addr, req_din, ram_dout,
    output gnt, rd_valid, rd_data, ram_wr, ram_addr, ram_din
  );
endinterface

// File: rtl/bram_port_arb.sv
// Shares one block-RAM port among NREQ requesters, with a registered command stage and tagged read return.
// Define BRAM_PORT_ARB_RR_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module bram_port_arb #(
  parameter int DATA = 15,
  parameter int ADDR = 6,
  parameter int NREQ = 4
) (
  input  logic          clk,
  input  logic          rst,
  bram_port_arb_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = IW + 1;

  logic            w_any;
  logic [IW-1:0]   w_idx;
  logic            r_ram_wr;
  logic [ADDR-1:0] r_ram_addr;
  logic [DATA-1:0] r_ram_din;
  logic            r_t1_v;
  logic [IW-1:0]   r_t1_idx;
  logic            r_t2_v;
  logic [IW-1:0]   r_t2_idx;

  // Held in reset, nothing may be granted even though req is live.
  assign w_any = (|bus.req) & ~rst;

`ifdef BRAM_PORT_ARB_RR_EN
  logic [IW-1:0] r_ptr;
  logic [SW-1:0] w_sum;

  // Descending offsets so the smallest offset from r_ptr with req high is the last assignment.
  always_comb begin
    w_idx = '0;
    w_sum = '0;
    for (int o = NREQ - 1; o >= 0; o--) begin
      w_sum = {1'b0, r_ptr} + SW'(o);
      if (w_sum >= SW'(NREQ)) w_sum = w_sum - SW'(NREQ);
      if (bus.req[w_sum[IW-1:0]]) w_idx = w_sum[IW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end
`else
  always_comb begin
    w_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) w_idx = IW'(i);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ram_wr   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_t1_v     <= 1'b0;
      r_t1_idx   <= '0;
      r_t2_v     <= 1'b0;
      r_t2_idx   <= '0;
    end else begin
      r_ram_wr <= w_any & bus.req_wr[w_idx];
      if (w_any) begin
        r_ram_addr <= bus.req_addr[w_idx*ADDR +: ADDR];
        r_ram_din  <= bus.req_din[w_idx*DATA +: DATA];
      end
      // Only reads carry a live tag; the RAM answers one cycle after the command stage.
      r_t1_v   <= w_any & ~bus.req_wr[w_idx];
      r_t1_idx <= w_idx;
      r_t2_v   <= r_t1_v;
      r_t2_idx <= r_t1_idx;
    end
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_dec
      assign bus.gnt[gi]      = w_any && (w_idx == IW'(gi));
      assign bus.rd_valid[gi] = r_t2_v && (r_t2_idx == IW'(gi));
    end
  endgenerate

  assign bus.ram_wr   = r_ram_wr;
  assign bus.ram_addr = r_ram_addr;
  assign bus.ram_din  = r_ram_din;
  assign bus.rd_data  = bus.ram_dout;
endmodule

// File: tb/tb_bram_port_arb.sv
// Directed and constrained-random bench for bram_port_arb with a behavioural RAM and a read scoreboard.
`timescale 1ns/1ps
module tb_bram_port_arb;
  localparam int DATA = 15;
  localparam int ADDR = 6;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bram_port_arb_if #(.DATA(DATA), .ADDR(ADDR), .NREQ(NREQ)) bus ();

  bram_port_arb #(.DATA(DATA), .ADDR(ADDR), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [DATA-1:0] pat(input int a);
    return DATA'(a * 331 + 7);
  endfunction

  // RAM: one-cycle registered read, never-written words return pat(addr).
  logic [DATA-1:0] ram_mem [64];
  bit              ram_wv  [64];
  always @(posedge clk) begin
    if (bus.ram_wr) begin
      ram_mem[bus.ram_addr] <= bus.ram_din;
      ram_wv[bus.ram_addr]  <= 1'b1;
    end
    bus.ram_dout <= ram_wv[bus.ram_addr] ? ram_mem[bus.ram_addr] : pat(int'(bus.ram_addr));
  end

  typedef struct {
    int              idx;
    logic [DATA-1:0] data;
    int              due;
  } rd_exp_t;

  rd_exp_t         sb[$];
  logic [DATA-1:0] exp_mem [64];
  int              m_ptr, m_last, cyc;
  int              n_chk, n_pass, n_fail;
  logic            exp_wr;
  logic [ADDR-1:0] exp_addr;
  logic [DATA-1:0] exp_din;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clr();
    bus.req    = '0;
    bus.req_wr = '0;
  endtask

  task automatic set_req(input int i, input bit wr, input int a, input logic [DATA-1:0] d);
    bus.req[i]                  = 1'b1;
    bus.req_wr[i]               = wr;
    bus.req_addr[i*ADDR +: ADDR] = ADDR'(a);
    bus.req_din[i*DATA +: DATA]  = d;
  endtask

  // One clock: check outputs at the falling edge, advance the model, step past the rising edge.
  task automatic cycle(input bit rst_mid = 1'b0);
    int              k, j;
    bit              win;
    logic [NREQ-1:0] eg, ev;
    @(negedge clk);
    chk("ram_wr", 64'(bus.ram_wr), 64'(exp_wr));
    chk("ram_addr", 64'(bus.ram_addr), 64'(exp_addr));
    chk("ram_din", 64'(bus.ram_din), 64'(exp_din));
    ev = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      ev[sb[0].idx] = 1'b1;
      chk("rd_data", 64'(bus.rd_data), 64'(sb[0].data));
      void'(sb.pop_front());
    end
    chk("rd_valid", 64'(bus.rd_valid), 64'(ev));
    win = 1'b0;
    k = 0;
    if (!rst) begin
`ifdef BRAM_PORT_ARB_RR_EN
      for (int o = 0; o < NREQ; o++) begin
        j = (m_ptr + o) % NREQ;
        if (!win && bus.req[j]) begin win = 1'b1; k = j; end
      end
`else
      for (int i = 0; i < NREQ; i++) begin
        if (!win && bus.req[i]) begin win = 1'b1; k = i; end
      end
`endif
    end
    eg = '0;
    if (win) eg[k] = 1'b1;
    chk("gnt", 64'(bus.gnt), 64'(eg));
    m_last = win ? k : -1;
    if (win) begin
      exp_wr   = bus.req_wr[k];
      exp_addr = bus.req_addr[k*ADDR +: ADDR];
      exp_din  = bus.req_din[k*DATA +: DATA];
      if (exp_wr) exp_mem[exp_addr] = exp_din;
      else sb.push_back('{idx: k, data: exp_mem[exp_addr], due: cyc + 2});
      m_ptr = (k + 1) % NREQ;
      $display("cyc %0d: accept req %0d %s addr %0d din %0h", cyc, k, exp_wr ? "write" : "read", exp_addr, exp_din);
    end else begin
      exp_wr = 1'b0;
    end
    if (rst_mid) begin
      #1 rst = 1'b1;
    end
    if (rst) begin
      sb.delete();
      m_ptr    = 0;
      exp_wr   = 1'b0;
      exp_addr = '0;
      exp_din  = '0;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req = '0; bus.req_wr = '0; bus.req_addr = '0; bus.req_din = '0;
    for (int a = 0; a < 64; a++) exp_mem[a] = pat(a);
    m_ptr = 0; m_last = -1; cyc = 0;
    n_chk = 0; n_pass = 0; n_fail = 0;
    exp_wr = 1'b0; exp_addr = '0; exp_din = '0;

    // Reset: every requester asking, yet nothing granted and all outputs at zero.
    bus.req = '1;
    repeat (2) cycle();
    clr();
    rst = 1'b0;
    cycle();

    // Single read by requester 2 of word 5.
    set_req(2, 1'b0, 5, '0);
    cycle();
    clr();
    repeat (3) cycle();

    // Write then immediate read-back of address 9 by requester 1.
    set_req(1, 1'b1, 9, 15'h1234);
    cycle();
    clr();
    set_req(1, 1'b0, 9, '0);
    cycle();
    clr();
    repeat (3) cycle();

    // Fairness: all four reading for 8 cycles, then requester 0 drops out.
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 10 + i, '0);
    repeat (8) cycle();
    bus.req[0] = 1'b0;
    repeat (2) cycle();
    clr();
    repeat (3) cycle();

    // Idle gap between two reads by requester 3, then an all-request probe of the pointer.
    set_req(3, 1'b0, 20, '0);
    cycle();
    clr();
    repeat (3) cycle();
    set_req(3, 1'b0, 21, '0);
    cycle();
    clr();
    repeat (3) cycle();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 40 + i, '0);
    cycle();
    clr();
    repeat (3) cycle();

    // Reset while two reads are in flight.
    set_req(0, 1'b0, 30, '0);
    cycle();
    clr();
    set_req(1, 1'b0, 31, '0);
    cycle(1'b1);
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 50 + i, '0);
    repeat (2) cycle();
    clr();
    rst = 1'b0;
    repeat (2) cycle();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 50 + i, '0);
    cycle();
    clr();
    repeat (3) cycle();

    // Random traffic; a pending command is held until its requester is granted.
    repeat (60) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req[i] || i == m_last) begin
          bus.req[i] = 1'b0;
          if ($urandom_range(0, 2) != 0)
            set_req(i, $urandom_range(0, 2) == 0, $urandom_range(0, 15), DATA'($urandom));
        end
      end
      cycle();
    end
    clr();
    repeat (4) cycle();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
